// File: rtl/fib_seq_controller.sv
// Fibonacci-style term generator: loads two seeds and emits n_terms terms of
// the sequence over a valid/ready stream, with abort and a sticky overflow flag.
module fib_seq_controller #(
    parameter int WIDTH = 17,
    parameter int CNT_W = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] n_terms,
    input  logic [WIDTH-1:0] seed_a,
    input  logic [WIDTH-1:0] seed_b,
    input  logic             abort,
    output logic             term_valid,
    input  logic             term_ready,
    output logic [WIDTH-1:0] term_data,
    output logic [CNT_W-1:0] term_idx,
    output logic             term_last,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [1:0]       dbg_state_o
);

    // Handshakes: a beat moves on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and payload is held while valid && !ready.
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] last_idx_q, last_idx_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   sum;

    // The carry bit of this sum drives the overflow flag.
    assign sum = {1'b0, a_q} + {1'b0, b_q};

    assign start_ready = (state_q == S_IDLE);
    assign term_valid  = (state_q == S_RUN);
    assign term_data   = a_q;
    assign term_idx    = idx_q;
    assign term_last   = (state_q == S_RUN) && (idx_q == last_idx_q);
    assign busy        = (state_q == S_RUN) || (state_q == S_DONE);
    assign done        = (state_q == S_DONE);
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        idx_d      = idx_q;
        last_idx_d = last_idx_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    a_d        = seed_a;
                    b_d        = seed_b;
                    idx_d      = '0;
                    last_idx_d = n_terms - CNT_W'(1);
                    ovf_d      = 1'b0;
                    state_d    = (n_terms != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // Abort wins over a transfer on the same edge.
                if (abort) begin
                    state_d = S_IDLE;
                end else if (term_ready) begin
                    a_d   = b_q;
                    b_d   = sum[WIDTH-1:0];
                    idx_d = idx_q + CNT_W'(1);
                    if (sum[WIDTH]) ovf_d = 1'b1;
                    if (term_last) state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            idx_q      <= '0;
            last_idx_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            idx_q      <= idx_d;
            last_idx_q <= last_idx_d;
            ovf_q      <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fib_seq_controller.sv
// Randomised bench for fib_seq_controller: a sequence-level model predicts every
// output each cycle; directed jobs pin the model with hand-computed sequences.
module tb_fib_seq_controller;
    localparam int WIDTH = 17;
    localparam int CNT_W = 5;
    localparam int TMAX  = 40;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [CNT_W-1:0] n_terms = '0;
    logic [WIDTH-1:0] seed_a = '0;
    logic [WIDTH-1:0] seed_b = '0;
    logic             abort = 1'b0;
    logic             term_valid;
    logic             term_ready = 1'b0;
    logic [WIDTH-1:0] term_data;
    logic [CNT_W-1:0] term_idx;
    logic             term_last;
    logic             busy;
    logic             done;
    logic             overflow;
    logic [1:0]       dbg_state;

    int checks = 0;
    int failures = 0;

    // Model: phase 0 = waiting for a job, 1 = emitting terms, 2 = completion cycle.
    int               m_phase = 0;
    int               m_n = 0;
    int               m_k = 0;
    logic             m_ovf = 1'b0;
    logic [WIDTH-1:0] m_terms [0:TMAX];
    logic             m_carry [0:TMAX];

    logic [WIDTH-1:0] act_q[$];
    logic [WIDTH-1:0] exp_q[$];

    fib_seq_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
        .n_terms(n_terms), .seed_a(seed_a), .seed_b(seed_b), .abort(abort),
        .term_valid(term_valid), .term_ready(term_ready), .term_data(term_data),
        .term_idx(term_idx), .term_last(term_last), .busy(busy), .done(done),
        .overflow(overflow), .dbg_state_o(dbg_state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0d exp=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Fibonacci recurrence mod 2^WIDTH; carry[j] marks the sum formed at transfer j.
    task automatic model_load(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        m_terms[0] = a;
        m_terms[1] = b;
        for (int i = 2; i <= TMAX; i++) begin
            s = {1'b0, m_terms[i-2]} + {1'b0, m_terms[i-1]};
            m_terms[i]   = s[WIDTH-1:0];
            m_carry[i-2] = s[WIDTH];
        end
    endtask

    task automatic compare();
        chk("start_ready", start_ready, m_phase == 0);
        chk("term_valid", term_valid, m_phase == 1);
        chk("busy", busy, m_phase != 0);
        chk("done", done, m_phase == 2);
        chk("overflow", overflow, m_ovf);
        chk("term_last", term_last, (m_phase == 1) && (m_k == m_n - 1));
        if (m_phase == 1) begin
            chk("term_data", term_data, m_terms[m_k]);
            chk("term_idx", term_idx, m_k);
        end
    endtask

    task automatic cycle();
        int nphase = m_phase;
        int nk = m_k;
        logic novf = m_ovf;
        if (term_valid && term_ready && !abort) act_q.push_back(term_data);
        case (m_phase)
            0: if (start_valid) begin
                model_load(seed_a, seed_b);
                m_n = int'(n_terms);
                nk = 0;
                novf = 1'b0;
                nphase = (n_terms != 0) ? 1 : 2;
            end
            1: if (abort) nphase = 0;
               else if (term_ready) begin
                   if (m_carry[m_k]) novf = 1'b1;
                   nk = m_k + 1;
                   if (m_k == m_n - 1) nphase = 2;
               end
            default: nphase = 0;
        endcase
        @(posedge clock);
        #1;
        m_phase = nphase;
        m_k = nk;
        m_ovf = novf;
        compare();
    endtask

    // ready_mode: 0 always ready, 1 pattern 1,0,0 repeating, 2 random.
    task automatic run_job(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                           input logic [CNT_W-1:0] n, input int ready_mode, input int abort_at);
        int guard = 0;
        seed_a = a;
        seed_b = b;
        n_terms = n;
        start_valid = 1'b1;
        cycle();
        start_valid = 1'b0;
        while (m_phase != 0 && guard < 200) begin
            seed_a = WIDTH'($urandom);
            seed_b = WIDTH'($urandom);
            n_terms = CNT_W'($urandom);
            case (ready_mode)
                0: term_ready = 1'b1;
                1: term_ready = (guard % 3 == 0);
                default: term_ready = 1'($urandom_range(0, 1));
            endcase
            abort = (abort_at >= 0) && (m_phase == 1) && (m_k == abort_at);
            cycle();
            guard++;
        end
        abort = 1'b0;
        term_ready = 1'b0;
        if (guard >= 200) chk("job_timeout", 1, 0);
    endtask

    task automatic check_seq(input string name);
        chk({name, "_len"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            chk(name, act_q[i], exp_q[i]);
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        #1;
        compare();
        chk("rst_idx", term_idx, 0);
        chk("rst_data", term_data, 0);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        cycle();

        run_job(17'd5, 17'd7, 5'd5, 0, -1);
        exp_q = '{17'd5, 17'd7, 17'd12, 17'd19, 17'd31};
        check_seq("seq_basic");

        run_job(17'd5, 17'd7, 5'd5, 1, -1);
        exp_q = '{17'd5, 17'd7, 17'd12, 17'd19, 17'd31};
        check_seq("seq_stall");

        run_job(17'd9, 17'd4, 5'd0, 0, -1);
        chk("zero_terms_cnt", act_q.size(), 0);
        act_q.delete();

        run_job(17'd65536, 17'd65536, 5'd3, 0, -1);
        exp_q = '{17'd65536, 17'd65536, 17'd0};
        chk("model_pin_wrap", m_terms[2], 0);
        chk("ovf_sticky", overflow, 1);
        check_seq("seq_wrap");
        cycle();
        chk("ovf_held_idle", overflow, 1);

        abort = 1'b1;
        cycle();
        abort = 1'b0;
        run_job(17'd3, 17'd4, 5'd6, 0, 2);
        exp_q = '{17'd3, 17'd4};
        check_seq("seq_abort");
        run_job(17'd1, 17'd1, 5'd4, 0, -1);
        exp_q = '{17'd1, 17'd1, 17'd2, 17'd3};
        check_seq("seq_after_abort");

        seed_a = 17'd2;
        seed_b = 17'd3;
        n_terms = 5'd10;
        start_valid = 1'b1;
        cycle();
        start_valid = 1'b0;
        term_ready = 1'b1;
        repeat (3) cycle();
        term_ready = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        m_phase = 0;
        m_k = 0;
        m_ovf = 1'b0;
        compare();
        chk("async_rst_idx", term_idx, 0);
        chk("async_rst_data", term_data, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        act_q.delete();
        cycle();
        run_job(17'd5, 17'd7, 5'd5, 0, -1);
        exp_q = '{17'd5, 17'd7, 17'd12, 17'd19, 17'd31};
        check_seq("seq_post_reset");

        run_job(WIDTH'($urandom), WIDTH'($urandom), 5'd31, 2, -1);
        chk("max_terms_cnt", act_q.size(), 31);
        act_q.delete();

        for (int j = 0; j < 30; j++) begin
            int n = $urandom_range(0, 31);
            int ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 31) : -1;
            run_job(WIDTH'($urandom), WIDTH'($urandom), CNT_W'(n), $urandom_range(0, 2), ab);
            act_q.delete();
            repeat ($urandom_range(0, 2)) begin
                abort = 1'($urandom_range(0, 1));
                cycle();
            end
            abort = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
